block_readout: RTL and testbench

BLOCK_READOUT -- requirements
Module: block_readout

---
 rtl/block_readout.sv | 109 ++++++++++
 tb/tb_block_readout.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_readout.sv
`default_nettype none
// ============================================================================
// block_readout : streams one 2^WIDTH-pixel block from a synchronous RAM
// through a 2-entry FIFO onto a valid/ready port.            Rev 1.0
// ============================================================================
module block_readout #(
  parameter int WIDTH  = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              rd_en,
  output logic [WIDTH-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH:0]    addr_q, addr_d;
  logic [WIDTH:0]    addr_next_w;
  logic              infl_q;        // read issued last cycle, its data is on rd_data now
  logic              infl_last_q;
  logic [DATA_W-1:0] mem_q [2];
  logic [1:0]        last_q;
  logic              rptr_q, wptr_q;
  logic [1:0]        cnt_q;
  logic              done_q;
  logic              hs_w, rd_en_w;
  logic [2:0]        load_w;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    addr_next_w = addr_q + (WIDTH+1)'(1);
    hs_w        = (cnt_q != 2'd0) && out_ready;
    // Entries that will still occupy the FIFO after this cycle's push/pop.
    load_w      = 3'(cnt_q) + 3'(infl_q) - 3'(hs_w);
    rd_en_w     = (state_q == S_READ) && (load_w < 3'd2);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          addr_d  = '0;
        end
      end
      S_READ: begin
        if (rd_en_w) begin
          addr_d = addr_next_w;
          if (addr_next_w[WIDTH]) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (hs_w && last_q[rptr_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      last_q      <= '0;
      rptr_q      <= 1'b0;
      wptr_q      <= 1'b0;
      cnt_q       <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      infl_q      <= rd_en_w;
      infl_last_q <= rd_en_w && addr_next_w[WIDTH];
      if (infl_q) begin
        mem_q[wptr_q]  <= rd_data;
        last_q[wptr_q] <= infl_last_q;
        wptr_q         <= ~wptr_q;
      end
      if (hs_w) rptr_q <= ~rptr_q;
      cnt_q  <= cnt_q + {1'b0, infl_q} - {1'b0, hs_w};
      done_q <= hs_w && last_q[rptr_q];
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign rd_en     = rd_en_w;
  assign rd_addr   = addr_q[WIDTH-1:0];
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rptr_q];
  assign out_last  = out_valid && last_q[rptr_q];
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_block_readout.sv
`default_nettype none
// ============================================================================
// tb_block_readout : scoreboard bench for block_readout (WIDTH=3).  Rev 1.0
// ============================================================================
module tb_block_readout;

  localparam int WIDTH  = 3;
  localparam int DATA_W = 8;
  localparam int NPIX   = 1 << WIDTH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic              busy, rd_en, out_valid, out_last, done;
  logic [WIDTH-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] ram [NPIX];

  block_readout #(.WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Shared bench model state
  logic [DATA_W:0] expq [$];
  bit  active = 1'b0;
  bit  new_blk = 1'b0;
  int  start_cyc = 0;
  int  ready_mode = 0;
  int  last_hs_cyc = -100;
  int  done_due = -1;
  int  done_cnt = 0;
  int  last_cnt = 0;
  int  hs_blk = 0;

  // Monitor state
  int              exp_addr = 0;
  int              issued = 0;
  bit              seen_valid = 1'b0;
  bit              prev_stall = 1'b0;
  logic [DATA_W:0] prev_beat = '0;
  logic [DATA_W:0] e;

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {busy, rd_en, out_valid, out_last, done, rd_addr, out_data}, 0);
      expq.delete();
      active     = 1'b0;
      prev_stall = 1'b0;
      done_due   = -1;
    end else begin
      if (new_blk) begin
        new_blk    = 1'b0;
        exp_addr   = 0;
        issued     = 0;
        hs_blk     = 0;
        seen_valid = 1'b0;
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_beat", {out_last, out_data}, prev_beat);
      end
      if (out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        chk("first_valid_cycle", cyc, start_cyc + 3);
      end
      if (out_valid && out_ready) begin
        hs_blk++;
        if (ready_mode == 0) chk("beat_cycle", cyc, start_cyc + 2 + hs_blk);
        if (out_last) last_cnt++;
        if (expq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("beat_data", out_data, e[DATA_W-1:0]);
          chk("beat_last", out_last, e[DATA_W]);
          if (e[DATA_W]) begin
            last_hs_cyc = cyc;
            done_due    = cyc + 1;
            active      = 1'b0;
          end
        end
      end
      if (rd_en) begin
        chk("rd_en_in_block", 32'(active && exp_addr < NPIX), 1);
        chk("rd_addr", rd_addr, exp_addr % NPIX);
        if (exp_addr == 0) chk("first_rd_cycle", cyc, start_cyc + 1);
        exp_addr++;
        issued++;
        chk("outstanding_le2", 32'(issued - hs_blk <= 2), 1);
      end
      if (done || cyc == done_due) begin
        chk("done_pulse", done, 32'(cyc == done_due));
        if (done) begin
          done_cnt++;
          chk("busy_low_at_done", busy, 0);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_last, out_data};
    end
  end

  // Downstream ready generator
  always begin
    @(posedge clk);
    #2;
    case (ready_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = !((cyc - start_cyc) >= 4 && (cyc - start_cyc) <= 8);
      default: out_ready = 1'b1;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue_start();
    start = 1'b1;
    if (!active) begin
      active    = 1'b1;
      new_blk   = 1'b1;
      start_cyc = cyc;
      for (int i = 0; i < NPIX; i++) expq.push_back({1'(i == NPIX - 1), ram[i]});
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (active && n < budget) begin
      step();
      n++;
    end
    chk("block_complete", active, 0);
  endtask

  int t0;
  int nblk = 0;

  initial begin
    for (int i = 0; i < NPIX; i++) ram[i] = DATA_W'(i + 16);
    repeat (3) step();
    rst = 1'b0;

    // Nominal block, started in the first cycle out of reset
    ready_mode = 0;
    issue_start();
    t0 = start_cyc;
    wait_idle(100);
    nblk++;
    chk("t1_last_beat_cycle", last_hs_cyc, t0 + 10);
    @(negedge clk);
    chk("t1_done_cycle", cyc, t0 + 11);
    chk("t1_done_busy", {done, busy}, 2'b10);
    repeat (2) step();

    // Back-pressure on cycles 4..8
    ready_mode = 2;
    step();
    issue_start();
    t0 = start_cyc;
    while (cyc < t0 + 8) step();
    @(negedge clk);
    chk("t2_held_17", {out_valid, out_data}, {1'b1, 8'd17});
    wait_idle(100);
    nblk++;
    repeat (2) step();

    // Start re-pulsed while busy, then a start in the done cycle
    ready_mode = 0;
    step();
    issue_start();
    t0 = start_cyc;
    while (cyc < t0 + 2) step();
    issue_start();
    while (cyc < t0 + 5) step();
    issue_start();
    wait_idle(100);
    nblk++;
    issue_start();
    chk("t3_restart_in_done", start_cyc, last_hs_cyc + 1);
    wait_idle(100);
    nblk++;
    repeat (2) step();

    // Reset after the 3rd handshake, then a fresh block
    issue_start();
    begin
      int n;
      n = 0;
      while (hs_blk < 3 && n < 50) begin
        step();
        n++;
      end
      chk("t4_three_beats", 32'(hs_blk >= 3), 1);
    end
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    issue_start();
    wait_idle(100);
    nblk++;

    // Random back-pressure and RAM contents over 20 back-to-back blocks
    ready_mode = 1;
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < NPIX; i++) ram[i] = DATA_W'($urandom);
      issue_start();
      wait_idle(300);
      nblk++;
    end
    repeat (4) step();

    chk("done_count", done_cnt, nblk);
    chk("last_count", last_cnt, nblk);
    chk("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
